// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NumReq = 8;
  localparam int unsigned SelW   = 3;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Wrap-around priority search: first set bit of req at or above start, wrapping past 7 to 0.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  logic [SelW-1:0]   start,
  output logic              found,
  output logic [SelW-1:0]   idx
);

  logic [SelW-1:0] pos;

  // Scan from the farthest candidate down so the nearest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      pos = start + SelW'(k);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arb_8to1.sv
// Round-robin arbiter for 8 requesters with a bounded hold time and a timeout pulse.
module rr_arb_8to1
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15  // legal range 1..255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              done,
  output logic [NumReq-1:0] gnt,
  output logic [SelW-1:0]   sel,
  output logic              busy,
  output logic              timeout
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [SelW-1:0]   last_q, last_d;
  logic [7:0]        hold_q, hold_d;
  logic              timeout_q, timeout_d;

  logic              found;
  logic [SelW-1:0]   idx;
  logic              at_limit;
  logic              release_now;

  // Search starts just past the previous owner so it becomes lowest priority.
  rr_pick8 u_pick (
    .req   (req),
    .start (last_q + SelW'(1)),
    .found (found),
    .idx   (idx)
  );

  assign at_limit    = (hold_q == HoldLast);
  assign release_now = done | ~req[sel_q] | at_limit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (found)       state_d = StBusy;
      StBusy:  if (release_now) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (found) begin
          gnt_d  = NumReq'(1) << idx;
          sel_d  = idx;
          last_d = idx;
          hold_d = '0;
        end
      end
      StBusy: begin
        if (release_now) begin
          // sel is kept so a downstream mux stays stable across the idle gap.
          gnt_d     = '0;
          timeout_d = at_limit & ~done & req[sel_q];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  // Output and bookkeeping registers; last resets to 7 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      sel_q     <= '0;
      last_q    <= SelW'(NumReq - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = (state_q == StBusy);
  assign timeout = timeout_q;

endmodule
